// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the UART TX scheduler.
//   state_t      : scheduler FSM encoding (IDLE/LOAD/ACK/DONE)
//   DEF_GAP_CYC  : default idle limit inside a locked packet
//   DEF_ACK_CYC  : default limit from tx_start to tx_busy rising
//   ID_W         : width of requester indices (up to 8 requesters)
//   next_id()    : round-robin successor of a requester index
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_GAP_CYC = 1024;
  localparam int DEF_ACK_CYC = 16;
  localparam int ID_W        = 3;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id, input int nreq);
    return (int'(id) == nreq - 1) ? '0 : id + ID_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr,
// wrapping NREQ-1 -> 0.
//   req    : request vector
//   ptr    : search start index (0..NREQ-1)
//   gnt    : one-hot grant (all zero when no request)
//   gnt_id : index of the granted request
//   any    : at least one request present
module uart_tx_sched_rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  always_comb begin
    int idx;
    idx    = 0;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART byte transmitter between NREQ requesters with round-robin
// arbitration and packet lock, plus lock-gap and engine-ack watchdogs.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/data/last   : per-requester byte offer (byte i on req_data[8i+7:8i])
//   req_ready             : one-hot acceptance pulse
//   tx_start, tx_data     : load strobe and byte for the TX engine
//   tx_busy               : engine transmitting
//   grant_id, locked      : current packet owner / packet in progress
//   err_gap, err_ack      : sticky watchdog flags
//
// state | meaning
// IDLE  | pick owner (or wait for owner's next byte while locked)
// LOAD  | capture byte, pulse tx_start and req_ready
// ACK   | wait for tx_busy to rise (ACK_CYC limit)
// DONE  | wait for tx_busy to fall, release lock after last byte
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int ACK_CYC = DEF_ACK_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [ID_W-1:0]   grant_id,
  output logic              locked,
  output logic              err_gap,
  output logic              err_ack
);

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int AW = $clog2(ACK_CYC + 1);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [NREQ-1:0]   sel_oh;
  logic [ID_W-1:0]   sel_id;
  logic              last_q;
  logic [GW-1:0]     gap_cnt;
  logic [AW-1:0]     ack_cnt;

  logic [NREQ-1:0]   arb_gnt;
  logic [ID_W-1:0]   arb_id;
  logic              arb_any;

  logic              valid_own;
  logic [7:0]        byte_sel;
  logic              last_sel;
  logic              arb_take, gap_fire, ack_fire, done_ok;

  uart_tx_sched_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  // sel_oh tracks the owner while locked, so it doubles as the valid/data mux select
  assign valid_own = |(req_valid & sel_oh);

  always_comb begin
    byte_sel = '0;
    last_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_oh[i]) begin
        byte_sel = req_data[8*i +: 8];
        last_sel = req_last[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arb_take  = 1'b0;
    gap_fire  = 1'b0;
    ack_fire  = 1'b0;
    done_ok   = 1'b0;
    case (state)
      ST_IDLE: begin
        // a busy engine here belongs to someone else: hold off until it falls
        if (locked) begin
          if (valid_own && !tx_busy)
            state_nxt = ST_LOAD;
          else if (!valid_own && gap_cnt == GW'(GAP_CYC - 1))
            gap_fire = 1'b1;
        end else if (arb_any && !tx_busy) begin
          arb_take  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: state_nxt = ST_ACK;
      ST_ACK: begin
        if (tx_busy) begin
          state_nxt = ST_DONE;
        end else if (ack_cnt == AW'(ACK_CYC - 1)) begin
          ack_fire  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!tx_busy) begin
          done_ok   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      sel_oh    <= '0;
      sel_id    <= '0;
      last_q    <= 1'b0;
      gap_cnt   <= '0;
      ack_cnt   <= '0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      grant_id  <= '0;
      locked    <= 1'b0;
      err_gap   <= 1'b0;
      err_ack   <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      req_ready <= '0;

      if (arb_take) begin
        sel_oh <= arb_gnt;
        sel_id <= arb_id;
      end

      if (state == ST_IDLE && locked && !valid_own && !gap_fire)
        gap_cnt <= gap_cnt + GW'(1);

      if (gap_fire) begin
        locked  <= 1'b0;
        err_gap <= 1'b1;
        gap_cnt <= '0;
        rr_ptr  <= next_id(grant_id, NREQ);
      end

      if (state == ST_LOAD) begin
        tx_data   <= byte_sel;
        last_q    <= last_sel;
        tx_start  <= 1'b1;
        req_ready <= sel_oh;
        locked    <= 1'b1;
        grant_id  <= sel_id;
        gap_cnt   <= '0;
        ack_cnt   <= '0;
      end

      if (state == ST_ACK && !tx_busy && !ack_fire)
        ack_cnt <= ack_cnt + AW'(1);

      if (ack_fire) begin
        err_ack <= 1'b1;
        locked  <= 1'b0;
        rr_ptr  <= next_id(grant_id, NREQ);
      end

      if (done_ok && last_q) begin
        locked <= 1'b0;
        rr_ptr <= next_id(grant_id, NREQ);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int GAP  = 40;
  localparam int ACKC = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [2:0]        grant_id;
  logic              locked;
  logic              err_gap;
  logic              err_ack;

  always #10 clk = ~clk;

  uart_tx_sched #(.NREQ(NREQ), .GAP_CYC(GAP), .ACK_CYC(ACKC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .locked    (locked),
    .err_gap   (err_gap),
    .err_ack   (err_ack)
  );

  typedef struct {logic [7:0] data; logic last;} beat_t;
  typedef struct {logic [7:0] data; int gid;} sent_t;
  typedef struct {int rid; logic [7:0] data; logic last; int exp_gid; logic exp_locked;} vec_t;

  beat_t rq [NREQ][$];
  sent_t log_q[$];

  int  errors = 0, checks = 0;
  int  rdy_cnt = 0, pushed = 0, ctl_viol = 0, stab_viol = 0;
  bit  eng_dead = 1'b0;
  bit  rnd_frame = 1'b0;
  int  frame_len = 10;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back('{d, l});
    pushed++;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k;
    k = 0;
    while ((log_q.size() < n || tx_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_count"}, log_q.size() >= n, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    log_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // requester side: pop on ready, present head of each queue
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (|req_ready) && (!tx_start || !$onehot(req_ready))) ctl_viol++;
      for (int i = 0; i < NREQ; i++) begin
        if (rst_n && req_ready[i]) begin
          rdy_cnt++;
          if (rq[i].size() > 0) void'(rq[i].pop_front());
        end
        if (rq[i].size() > 0) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = rq[i][0].data;
          req_last[i]         = rq[i][0].last;
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = '0;
          req_last[i]         = 1'b0;
        end
      end
    end
  end

  // TX engine model: busy one cycle after tx_start, for frame_len cycles
  initial begin
    int cnt;
    logic [7:0] held;
    tx_busy = 1'b0;
    cnt = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_busy = 1'b0;
        cnt = 0;
      end else if (tx_busy) begin
        if (tx_start) ctl_viol++;
        if (tx_data !== held) stab_viol++;
        cnt--;
        if (cnt <= 0) tx_busy = 1'b0;
      end else if (tx_start && !eng_dead) begin
        held = tx_data;
        log_q.push_back('{tx_data, int'(grant_id)});
        tx_busy = 1'b1;
        cnt = rnd_frame ? int'($urandom_range(3, 12)) : frame_len;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end

  initial begin
    vec_t  vt[6];
    int    lat, base, cnt, nst, n_at_gap;
    sent_t expq[$];
    beat_t gen [NREQ][$];

    vt[0] = '{0, 8'h11, 1'b1, 0, 1'b0};
    vt[1] = '{2, 8'h22, 1'b0, 2, 1'b1};
    vt[2] = '{2, 8'h23, 1'b1, 2, 1'b0};
    vt[3] = '{3, 8'hF0, 1'b1, 3, 1'b0};
    vt[4] = '{1, 8'h00, 1'b0, 1, 1'b1};
    vt[5] = '{1, 8'hFF, 1'b1, 1, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start",  tx_start,  0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_locked",    locked,    0);
    chk("rst_grant_id",  grant_id,  0);
    chk("rst_err_flags", {err_gap, err_ack}, 0);
    chk("rst_tx_data",   tx_data,   0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single requester, latency and hold
    sync();
    push(0, 8'h55, 1'b1);
    @(negedge clk);
    lat = 0;
    while (!tx_start && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("t1_latency", lat, 2);
    wait_log(1, 300, "t1");
    if (log_q.size() > 0) begin
      chk("t1_data", log_q[0].data, 8'h55);
      chk("t1_gid",  log_q[0].gid,  0);
    end
    chk("t1_locked", locked, 0);
    chk("t1_ready_cnt", rdy_cnt, 1);

    // table of single-byte offers, one at a time
    for (int v = 0; v < 6; v++) begin
      base = log_q.size();
      sync();
      push(vt[v].rid, vt[v].data, vt[v].last);
      wait_log(base + 1, 300, $sformatf("vec%0d", v));
      if (log_q.size() > base) begin
        chk($sformatf("vec%0d_data", v), log_q[base].data, vt[v].data);
        chk($sformatf("vec%0d_gid", v),  log_q[base].gid,  vt[v].exp_gid);
      end
      chk($sformatf("vec%0d_locked", v), locked, vt[v].exp_locked);
    end

    // 2: contention from rr_ptr=0, then prove pointer wrapped to 0
    do_reset();
    sync();
    push(1, 8'h31, 1'b1);
    push(3, 8'h93, 1'b1);
    wait_log(2, 600, "t2");
    if (log_q.size() >= 2) begin
      chk("t2_first_gid",  log_q[0].gid, 1);
      chk("t2_second_gid", log_q[1].gid, 3);
      chk("t2_second_dat", log_q[1].data, 8'h93);
    end
    sync();
    push(2, 8'h42, 1'b1);
    push(0, 8'h04, 1'b1);
    wait_log(4, 600, "t2b");
    if (log_q.size() >= 4) begin
      chk("t2_ptr_wrap_gid", log_q[2].gid, 0);
      chk("t2_then_gid",     log_q[3].gid, 2);
    end

    // 3: packet lock against a competing requester
    base = log_q.size();
    sync();
    push(0, 8'hA1, 1'b0);
    push(0, 8'hA2, 1'b0);
    push(0, 8'hA3, 1'b1);
    push(2, 8'h5C, 1'b1);
    wait_log(base + 4, 1200, "t3");
    if (log_q.size() >= base + 4) begin
      chk("t3_b0", {log_q[base].data,   8'(log_q[base].gid)},   {8'hA1, 8'd0});
      chk("t3_b1", {log_q[base+1].data, 8'(log_q[base+1].gid)}, {8'hA2, 8'd0});
      chk("t3_b2", {log_q[base+2].data, 8'(log_q[base+2].gid)}, {8'hA3, 8'd0});
      chk("t3_b3", {log_q[base+3].data, 8'(log_q[base+3].gid)}, {8'h5C, 8'd2});
    end

    // 4: lock gap timeout
    base = log_q.size();
    sync();
    push(1, 8'h61, 1'b0);
    cnt = 0;
    while (!(locked && grant_id == 3'd1) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    push(2, 8'h62, 1'b1);
    cnt = 0;
    while ((log_q.size() <= base || tx_busy) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_err_gap_early", err_gap, 0);
    cnt = 0;
    while (!err_gap && cnt < GAP + 20) begin
      @(negedge clk);
      cnt++;
    end
    n_at_gap = log_q.size();
    chk("t4_gap_window", (cnt >= GAP && cnt <= GAP + 1), 1);
    chk("t4_no_steal", n_at_gap, base + 1);
    wait_log(base + 2, 300, "t4");
    if (log_q.size() >= base + 2)
      chk("t4_next_gid", log_q[base+1].gid, 2);
    chk("t4_err_gap_sticky", err_gap, 1);
    chk("t4_locked", locked, 0);

    // 5: dead engine
    eng_dead = 1'b1;
    sync();
    push(0, 8'h7E, 1'b1);
    cnt = 0;
    while (!tx_start && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("t5_tx_data", tx_data, 8'h7E);
    cnt = 0;
    while (!err_ack && cnt < ACKC + 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("t5_ack_cycles", cnt, ACKC);
    @(negedge clk);
    chk("t5_locked", locked, 0);
    nst = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_start) nst++;
    end
    chk("t5_no_restart", nst, 0);
    eng_dead = 1'b0;

    // 6: reset during DONE
    sync();
    push(2, 8'hC3, 1'b1);
    cnt = 0;
    while (!tx_busy && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_outputs_zero",
        {tx_start, req_ready, locked, grant_id, err_gap, err_ack, tx_data}, 0);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    log_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sync();
    push(0, 8'h33, 1'b1);
    wait_log(1, 300, "t6");
    if (log_q.size() > 0) chk("t6_data", {log_q[0].data, 8'(log_q[0].gid)}, {8'h33, 8'd0});
    chk("t6_locked", locked, 0);
    chk("t6_flags_clear", {err_gap, err_ack}, 0);

    // randomized packets against a packet-level round-robin model
    rnd_frame = 1'b1;
    for (int it = 0; it < 3; it++) begin
      int ptr, found, nb;
      beat_t b;
      do_reset();
      nb = 0;
      for (int i = 0; i < NREQ; i++) begin
        gen[i].delete();
        repeat ($urandom_range(0, 3)) begin
          int len;
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) begin
            gen[i].push_back('{8'($urandom_range(0, 255)), (j == len - 1)});
            nb++;
          end
        end
      end
      expq.delete();
      ptr = 0;
      forever begin
        found = -1;
        for (int off = 0; off < NREQ; off++)
          if (found < 0 && gen[(ptr + off) % NREQ].size() > 0) found = (ptr + off) % NREQ;
        if (found < 0) break;
        do begin
          b = gen[found][0];
          expq.push_back('{b.data, found});
          push(found, b.data, b.last);
          void'(gen[found].pop_front());
        end while (!b.last);
        ptr = (found + 1) % NREQ;
      end
      // model consumed gen while pushing; all offers land in the same cycle
      sync();
      wait_log(nb, 5000, $sformatf("rnd%0d", it));
      for (int k = 0; k < expq.size(); k++) begin
        if (k < log_q.size())
          chk($sformatf("rnd%0d_b%0d", it, k),
              {log_q[k].data, 8'(log_q[k].gid)}, {expq[k].data, 8'(expq[k].gid)});
      end
      chk($sformatf("rnd%0d_locked", it), locked, 0);
    end

    chk("ready_per_byte", rdy_cnt, pushed);
    chk("ready_with_start_onehot", ctl_viol, 0);
    chk("tx_data_stable", stab_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
